// File: rtl/per_arb_pkg.sv
// Package per_arb_pkg
//   Shared types and constants for the peripheral master-port arbiter.
//   - arb_state_e : arbiter FSM states (ARB_IDLE / ARB_LOCKED)
//   - id_width()  : width of a requester ID, $clog2(N_REQ) with a floor of 1
//   - BE_ALL      : all-bytes-enabled constant for the 32-bit data path
package per_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam logic [3:0] BE_ALL = '1;

  function automatic int unsigned id_width(input int unsigned n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/per_arb_id_fifo.sv
// Module per_arb_id_fifo
//   Synchronous FIFO holding the IDs of granted-but-unanswered transfers, so
//   in-order responses can be routed back to the requester that issued them.
// Ports
//   clk_i    in   clock
//   rst_i    in   synchronous reset, active-high (empties the FIFO)
//   push_i   in   write data_i (ignored when full)
//   data_i   in   ID to store
//   pop_i    in   drop the head entry (ignored when empty)
//   full_o   out  DEPTH entries stored
//   empty_o  out  no entries stored
//   head_o   out  oldest stored ID (valid when !empty_o)
module per_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count already
  // mark every entry invalid, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/per_master_arbiter.sv
// Module per_master_arbiter
//   Shares one peripheral-interconnect master port between N_REQ requesters
//   with round-robin arbitration. A requester that is not granted in its
//   first cycle is locked so the master fields stay stable until gnt.
//   Response IDs are tracked in an in-order FIFO (per_arb_id_fifo).
// Ports
//   clk_i / rst_i                 clock, synchronous active-high reset
//   slv_req_i/add_i/we_i/wdata_i/be_i   packed per-requester request fields
//   slv_gnt_o                     grant, one-hot or zero (same cycle as master gnt)
//   slv_r_valid_o / slv_r_opc_o   response valid / error routed to the head ID
//   slv_r_rdata_o                 read data, broadcast
//   per_master_*_o                request towards the interconnect
//   per_master_gnt_i, per_master_r_valid_i/opc_i/rdata_i   interconnect side
//   resp_err_o                    response arrived with no outstanding ID
//   grant_cnt_o                   16-bit saturating grant counter per requester,
//                                 present only when PER_ARB_STATS_EN is defined
module per_master_arbiter
  import per_arb_pkg::*;
#(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned PER_ADDR_WIDTH  = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            slv_req_i,
  input  logic [N_REQ*PER_ADDR_WIDTH-1:0] slv_add_i,
  input  logic [N_REQ-1:0]            slv_we_i,
  input  logic [N_REQ*32-1:0]         slv_wdata_i,
  input  logic [N_REQ*4-1:0]          slv_be_i,
  output logic [N_REQ-1:0]            slv_gnt_o,
  output logic [N_REQ-1:0]            slv_r_valid_o,
  output logic [N_REQ-1:0]            slv_r_opc_o,
  output logic [31:0]                 slv_r_rdata_o,
  output logic                        per_master_req_o,
  output logic [PER_ADDR_WIDTH-1:0]   per_master_add_o,
  output logic                        per_master_we_o,
  output logic [31:0]                 per_master_wdata_o,
  output logic [3:0]                  per_master_be_o,
  input  logic                        per_master_gnt_i,
  input  logic                        per_master_r_valid_i,
  input  logic                        per_master_r_opc_i,
  input  logic [31:0]                 per_master_r_rdata_i,
`ifdef PER_ARB_STATS_EN
  output logic [N_REQ*16-1:0]         grant_cnt_o,
`endif
  output logic                        resp_err_o
);

  localparam int unsigned ID_W = id_width(N_REQ);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] locked_q, locked_d;
  logic [ID_W-1:0] rr_q, rr_d;

  logic [ID_W-1:0] win_idx, sel_idx;
  logic            win_found, sel_valid;
  logic            master_req, grant, pop;
  logic            fifo_full, fifo_empty;
  logic [ID_W-1:0] fifo_head;

  function automatic logic [ID_W-1:0] idx_inc(input logic [ID_W-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Round-robin winner: scan downwards so the lowest offset from rr_q wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (slv_req_i[(int'(rr_q) + i) % N_REQ]) begin
        win_idx   = ID_W'((int'(rr_q) + i) % N_REQ);
        win_found = 1'b1;
      end
    end
  end

  // While locked, only the locked requester may drive the master port.
  assign sel_idx   = (state_q == ARB_LOCKED) ? locked_q : win_idx;
  assign sel_valid = (state_q == ARB_LOCKED) ? slv_req_i[locked_q] : win_found;

  // Full blocks the request even if a response pops this cycle, which keeps
  // r_valid off the combinational path to per_master_req_o.
  assign master_req = sel_valid && !fifo_full && !rst_i;
  assign grant      = master_req && per_master_gnt_i;
  assign pop        = per_master_r_valid_i && !fifo_empty && !rst_i;

  per_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .data_i  (sel_idx),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      locked_q <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      rr_q     <= rr_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    rr_d     = rr_q;
    if (grant) rr_d = idx_inc(sel_idx);
    case (state_q)
      ARB_IDLE: begin
        if (master_req && !per_master_gnt_i) begin
          state_d  = ARB_LOCKED;
          locked_d = win_idx;
        end
      end
      ARB_LOCKED: begin
        // A dropped request is a protocol violation: release without a push.
        if (!slv_req_i[locked_q] || grant) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    per_master_req_o   = 1'b0;
    per_master_add_o   = '0;
    per_master_we_o    = 1'b0;
    per_master_wdata_o = '0;
    per_master_be_o    = '0;
    slv_gnt_o          = '0;
    slv_r_valid_o      = '0;
    slv_r_opc_o        = '0;
    slv_r_rdata_o      = '0;
    resp_err_o         = 1'b0;
    if (master_req) begin
      per_master_req_o   = 1'b1;
      per_master_add_o   = slv_add_i[int'(sel_idx)*PER_ADDR_WIDTH +: PER_ADDR_WIDTH];
      per_master_we_o    = slv_we_i[sel_idx];
      per_master_wdata_o = slv_wdata_i[int'(sel_idx)*32 +: 32];
      per_master_be_o    = slv_be_i[int'(sel_idx)*4 +: 4];
      slv_gnt_o[sel_idx] = per_master_gnt_i;
    end
    if (per_master_r_valid_i && !rst_i) begin
      if (fifo_empty) begin
        resp_err_o = 1'b1;
      end else begin
        slv_r_valid_o[fifo_head] = 1'b1;
        slv_r_opc_o[fifo_head]   = per_master_r_opc_i;
        slv_r_rdata_o            = per_master_r_rdata_i;
      end
    end
  end

`ifdef PER_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] grant_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (slv_gnt_o[i] && grant_cnt_q[i] != 16'hFFFF)
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_per_master_arbiter.sv
// Directed testbench for per_master_arbiter (N_REQ=4, AW=32, MAX_OUTSTANDING=2).
// Inputs change 1 time unit after the rising edge; outputs are compared 1 unit
// later, well before the next edge.
module tb_per_master_arbiter;
  import per_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    slv_req_i;
  logic [N*AW-1:0] slv_add_i;
  logic [N-1:0]    slv_we_i;
  logic [N*32-1:0] slv_wdata_i;
  logic [N*4-1:0]  slv_be_i;
  logic [N-1:0]    slv_gnt_o, slv_r_valid_o, slv_r_opc_o;
  logic [31:0]     slv_r_rdata_o;
  logic            per_master_req_o, per_master_we_o;
  logic [AW-1:0]   per_master_add_o;
  logic [31:0]     per_master_wdata_o;
  logic [3:0]      per_master_be_o;
  logic            per_master_gnt_i, per_master_r_valid_i, per_master_r_opc_i;
  logic [31:0]     per_master_r_rdata_i;
  logic            resp_err_o;
`ifdef PER_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt_o;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  per_master_arbiter #(.N_REQ(N), .PER_ADDR_WIDTH(AW), .MAX_OUTSTANDING(2)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .slv_req_i            (slv_req_i),
    .slv_add_i            (slv_add_i),
    .slv_we_i             (slv_we_i),
    .slv_wdata_i          (slv_wdata_i),
    .slv_be_i             (slv_be_i),
    .slv_gnt_o            (slv_gnt_o),
    .slv_r_valid_o        (slv_r_valid_o),
    .slv_r_opc_o          (slv_r_opc_o),
    .slv_r_rdata_o        (slv_r_rdata_o),
    .per_master_req_o     (per_master_req_o),
    .per_master_add_o     (per_master_add_o),
    .per_master_we_o      (per_master_we_o),
    .per_master_wdata_o   (per_master_wdata_o),
    .per_master_be_o      (per_master_be_o),
    .per_master_gnt_i     (per_master_gnt_i),
    .per_master_r_valid_i (per_master_r_valid_i),
    .per_master_r_opc_i   (per_master_r_opc_i),
    .per_master_r_rdata_i (per_master_r_rdata_i),
`ifdef PER_ARB_STATS_EN
    .grant_cnt_o          (grant_cnt_o),
`endif
    .resp_err_o           (resp_err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv,
                       input logic opc, input logic [31:0] rdata);
    slv_req_i            = req;
    per_master_gnt_i     = gnt;
    per_master_r_valid_i = rv;
    per_master_r_opc_i   = opc;
    per_master_r_rdata_i = rdata;
    #1;
  endtask

  function automatic logic [31:0] exp_add(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  initial begin
    rst_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      slv_add_i[i*AW +: AW]  = exp_add(i);
      slv_we_i[i]            = i[0];
      slv_wdata_i[i*32 +: 32] = 32'hD000_0000 + 32'(i);
      slv_be_i[i*4 +: 4]     = i[0] ? 4'h3 : BE_ALL;
    end
    drive('0, 1'b0, 1'b0, 1'b0, '0);
    tick(); tick();
    check("rst_master_req", 64'(per_master_req_o), 64'd0);
    check("rst_slv_gnt", 64'(slv_gnt_o), 64'd0);
    check("rst_resp_err", 64'(resp_err_o), 64'd0);

    // 1. single request, response next cycle
    rst_i = 1'b0;
    drive(4'b0001, 1'b1, 1'b0, 1'b0, '0);
    check("t1_master_req", 64'(per_master_req_o), 64'd1);
    check("t1_add", 64'(per_master_add_o), 64'h1000_0000);
    check("t1_be", 64'(per_master_be_o), 64'hF);
    check("t1_gnt", 64'(slv_gnt_o), 64'b0001);
    tick();
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001);
    check("t1_r_valid", 64'(slv_r_valid_o), 64'b0001);
    check("t1_rdata", 64'(slv_r_rdata_o), 64'hCAFE_0001);
    check("t1_no_err", 64'(resp_err_o), 64'd0);
    tick();

    // 2. all requesters held: fresh reset so rr restarts at 0
    rst_i = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(4'b1111, 1'b1, k != 0, 1'b0, 32'h100 + 32'(k));
      check($sformatf("t2_gnt_%0d", k), 64'(slv_gnt_o), 64'(4'b0001 << (k % 4)));
      check($sformatf("t2_rv_%0d", k), 64'(slv_r_valid_o),
            (k == 0) ? 64'd0 : 64'(4'b0001 << ((k - 1) % 4)));
      tick();
    end
    drive(4'b0000, 1'b0, 1'b1, 1'b0, '0);
    check("t2_drain_rv", 64'(slv_r_valid_o), 64'b1000);
`ifdef PER_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      check($sformatf("t2_stats_%0d", i), 64'(grant_cnt_o[i*16 +: 16]), 64'd4);
`endif
    tick();

    // 3. req[2] waits 3 cycles, req[1] arrives while 2 is locked (rr=0, empty)
    drive(4'b0100, 1'b0, 1'b0, 1'b0, '0);
    check("t3_c0_add", 64'(per_master_add_o), 64'h1000_0200);
    check("t3_c0_gnt", 64'(slv_gnt_o), 64'd0);
    tick();
    drive(4'b0110, 1'b0, 1'b0, 1'b0, '0);
    check("t3_c1_add", 64'(per_master_add_o), 64'h1000_0200);
    tick();
    drive(4'b0110, 1'b0, 1'b0, 1'b0, '0);
    check("t3_c2_add", 64'(per_master_add_o), 64'h1000_0200);
    tick();
    drive(4'b0110, 1'b1, 1'b0, 1'b0, '0);
    check("t3_c3_gnt", 64'(slv_gnt_o), 64'b0100);
    tick();
    drive(4'b0010, 1'b1, 1'b1, 1'b0, '0);
    check("t3_c4_gnt", 64'(slv_gnt_o), 64'b0010);
    check("t3_c4_rv", 64'(slv_r_valid_o), 64'b0100);
    tick();
    drive(4'b0000, 1'b0, 1'b1, 1'b1, '0);
    check("t3_c5_rv", 64'(slv_r_valid_o), 64'b0010);
    check("t3_c5_opc", 64'(slv_r_opc_o), 64'b0010);
    tick();

    // 4. two grants fill the FIFO (rr=2, empty)
    drive(4'b0001, 1'b1, 1'b0, 1'b0, '0);
    check("t4_g0", 64'(slv_gnt_o), 64'b0001);
    tick();
    drive(4'b1000, 1'b1, 1'b0, 1'b0, '0);
    check("t4_g3", 64'(slv_gnt_o), 64'b1000);
    check("t4_we", 64'(per_master_we_o), 64'd1);
    check("t4_wdata", 64'(per_master_wdata_o), 64'hD000_0003);
    check("t4_be", 64'(per_master_be_o), 64'h3);
    tick();
    drive(4'b0010, 1'b1, 1'b0, 1'b0, '0);
    check("t4_full_req", 64'(per_master_req_o), 64'd0);
    check("t4_full_gnt", 64'(slv_gnt_o), 64'd0);
    tick();
    drive(4'b0010, 1'b1, 1'b1, 1'b0, '0);
    check("t4_pop_req", 64'(per_master_req_o), 64'd0);
    check("t4_pop_rv", 64'(slv_r_valid_o), 64'b0001);
    tick();
    drive(4'b0010, 1'b0, 1'b0, 1'b0, '0);
    check("t4_free_req", 64'(per_master_req_o), 64'd1);
    check("t4_free_add", 64'(per_master_add_o), 64'h1000_0100);
    tick();
    drive(4'b0010, 1'b1, 1'b1, 1'b0, '0);
    check("t4_g1", 64'(slv_gnt_o), 64'b0010);
    check("t4_rv3", 64'(slv_r_valid_o), 64'b1000);
    tick();
    drive(4'b0000, 1'b0, 1'b1, 1'b0, '0);
    check("t4_rv1", 64'(slv_r_valid_o), 64'b0010);
    tick();

    // 5. response with empty FIFO (rr=2)
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 32'h1234);
    check("t5_err", 64'(resp_err_o), 64'd1);
    check("t5_rv", 64'(slv_r_valid_o), 64'd0);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 1'b0, '0);
    check("t5_err_end", 64'(resp_err_o), 64'd0);
    // locked requester drops req: no push, so a later response is an error
    drive(4'b0001, 1'b0, 1'b0, 1'b0, '0);
    check("t5_lock_req", 64'(per_master_req_o), 64'd1);
    tick();
    drive(4'b0000, 1'b0, 1'b0, 1'b0, '0);
    check("t5_drop_req", 64'(per_master_req_o), 64'd0);
    tick();
    drive(4'b0000, 1'b0, 1'b1, 1'b0, '0);
    check("t5_drop_err", 64'(resp_err_o), 64'd1);
    tick();

    // 6. reset while LOCKED with one outstanding (rr=2)
    drive(4'b0100, 1'b1, 1'b0, 1'b0, '0);
    check("t6_g2", 64'(slv_gnt_o), 64'b0100);
    tick();
    drive(4'b0001, 1'b0, 1'b0, 1'b0, '0);
    check("t6_lock_add", 64'(per_master_add_o), 64'h1000_0000);
    tick();
    rst_i = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 1'b0, '0);
    tick();
    rst_i = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 1'b0, '0);
    check("t6_req", 64'(per_master_req_o), 64'd0);
    check("t6_gnt", 64'(slv_gnt_o), 64'd0);
    check("t6_rv", 64'(slv_r_valid_o), 64'd0);
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 32'hBAD);
    check("t6_late_err", 64'(resp_err_o), 64'd1);
    check("t6_late_rv", 64'(slv_r_valid_o), 64'd0);
    drive(4'b0010, 1'b0, 1'b0, 1'b0, '0);
    check("t6_unlock_req", 64'(per_master_req_o), 64'd1);
    check("t6_unlock_add", 64'(per_master_add_o), 64'h1000_0100);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
